// File: rtl/ifu_fetch_if.sv
// Fetch-unit boundary bundle: imem request/response, decode handoff, predecoder and EXU redirect.
// master = fetch unit, slave = the surrounding pipeline/memory.
interface ifu_fetch_if #(
  parameter int XLEN = 32
);
  logic            req_valid_o;
  logic            req_ready_i;
  logic [XLEN-1:0] req_addr_o;
  logic            rsp_valid_i;
  logic            rsp_ready_o;
  logic [31:0]     rsp_data_i;
  logic            rsp_err_i;
  logic            inst_valid_o;
  logic            inst_ready_i;
  logic [31:0]     inst_o;
  logic [XLEN-1:0] pc_o;
  logic            fetch_err_o;
  logic [XLEN-1:0] pred_pc_i;
  logic            redirect_valid_i;
  logic [XLEN-1:0] redirect_pc_i;

  modport master (
    output req_valid_o, req_addr_o, rsp_ready_o,
    output inst_valid_o, inst_o, pc_o, fetch_err_o,
    input  req_ready_i, rsp_valid_i, rsp_data_i, rsp_err_i,
    input  inst_ready_i, pred_pc_i, redirect_valid_i, redirect_pc_i
  );

  modport slave (
    input  req_valid_o, req_addr_o, rsp_ready_o,
    input  inst_valid_o, inst_o, pc_o, fetch_err_o,
    output req_ready_i, rsp_valid_i, rsp_data_i, rsp_err_i,
    output inst_ready_i, pred_pc_i, redirect_valid_i, redirect_pc_i
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch: one outstanding imem request, REQ -> WAIT -> HOLD, 1 inst per 3 cycles at best.
// Decode backpressure holds the instruction in HOLD; redirects override prediction in every state.
module ifu_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  ifu_fetch_if.master   bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD} state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic            drop_q;
  logic            req_vld_q;
  logic            rsp_rdy_q;
  logic            inst_vld_q;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            err_q;

  logic            redirect;
  logic [XLEN-1:0] redir_pc_d;

  assign redirect   = bus.redirect_valid_i;
  assign redir_pc_d = {bus.redirect_pc_i[XLEN-1:2], 2'b00};

  assign bus.req_valid_o  = req_vld_q;
  assign bus.req_addr_o   = pc_q;
  assign bus.rsp_ready_o  = rsp_rdy_q;
  assign bus.inst_valid_o = inst_vld_q;
  assign bus.inst_o       = inst_q;
  assign bus.pc_o         = inst_pc_q;
  assign bus.fetch_err_o  = err_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      req_vld_q  <= 1'b0;
      rsp_rdy_q  <= 1'b0;
      inst_vld_q <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q   <= ST_REQ;
          req_vld_q <= 1'b1;
        end
        ST_REQ: begin
          if (bus.req_ready_i) begin
            state_q   <= ST_WAIT;
            req_vld_q <= 1'b0;
            rsp_rdy_q <= 1'b1;
            drop_q    <= redirect;
          end
        end
        ST_WAIT: begin
          if (bus.rsp_valid_i) begin
            rsp_rdy_q <= 1'b0;
            drop_q    <= 1'b0;
            // A stale or concurrently redirected response is thrown away and refetched.
            if (drop_q || redirect) begin
              state_q   <= ST_REQ;
              req_vld_q <= 1'b1;
            end else begin
              state_q    <= ST_HOLD;
              inst_vld_q <= 1'b1;
              inst_q     <= bus.rsp_data_i;
              inst_pc_q  <= pc_q;
              err_q      <= bus.rsp_err_i;
            end
          end else if (redirect) begin
            drop_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (redirect || bus.inst_ready_i) begin
            state_q    <= ST_REQ;
            req_vld_q  <= 1'b1;
            inst_vld_q <= 1'b0;
            if (!redirect) pc_q <= bus.pred_pc_i;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      if (redirect) pc_q <= redir_pc_d;
    end
  end

endmodule
